uart_rx_fifo: RTL and testbench

- Second-generation UART serial receiver.
- Runtime-configurable frame: 5–8 data bits, none/even/odd/mark/space parity, 1 or 2 stop bits.
- Uses 3-point majority sampling and a 2-flop input synchroniser.
- Detects framing, parity, break and overrun errors.
- Queues received bytes with per-byte error flags in an internal synchronous FIFO, drained by a valid/ready stream. Sits between the pad and the peripheral register block.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receiver: frame configuration codes, FSM states
// and the bit layout of a queued FIFO entry.
package uart_pkg;

  localparam logic [2:0] PARITY_NONE  = 3'd0;
  localparam logic [2:0] PARITY_EVEN  = 3'd1;
  localparam logic [2:0] PARITY_ODD   = 3'd2;
  localparam logic [2:0] PARITY_MARK  = 3'd3;
  localparam logic [2:0] PARITY_SPACE = 3'd4;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } state_t;

  localparam int ENTRY_WIDTH = 11;
  localparam int DATA_LSB    = 0;
  localparam int DATA_MSB    = 7;
  localparam int FRAME_BIT   = 8;
  localparam int PARITY_BIT  = 9;
  localparam int BREAK_BIT   = 10;

  // Codes 5-7 are reserved and behave as no parity.
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode >= PARITY_EVEN) && (mode <= PARITY_SPACE);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO; head is read combinationally from the read pointer.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-point majority sampling, configurable framing and a
// receive FIFO carrying per-byte framing/parity/break flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int FIFO_DEPTH_LOG2     = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           serial_i,
  input  logic [1:0]                     data_bits_i,
  input  logic [2:0]                     parity_mode_i,
  input  logic                           stop_bits_i,
  output logic [7:0]                     data_o,
  output logic                           frame_err_o,
  output logic                           parity_err_o,
  output logic                           break_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [FIFO_DEPTH_LOG2:0]       level_o,
  output logic                           overrun_o,
  input  logic                           clear_overrun_i
);

  localparam int CW = CLOCK_DIVIDER_WIDTH;

  state_t           state, state_nxt;
  logic             sync1, rx_s;
  logic [CW-1:0]    timer, mid;
  logic             armed;
  logic [1:0]       cfg_bits;
  logic [2:0]       cfg_par;
  logic             cfg_stop;
  logic             s_a, s_b, maj;
  logic             at_mid_p1, at_mid, resolve;
  logic [2:0]       bit_idx, last_idx;
  logic             stop_idx;
  logic [7:0]       shreg;
  logic             frame_err, par_err, all_zero, exp_par;
  logic             div_ok, start_go, push;
  logic             fifo_full, fifo_empty, pop;
  logic [ENTRY_WIDTH-1:0] entry, head;

  assign mid       = clock_divider_i >> 1;
  assign at_mid_p1 = (timer == mid + CW'(1));
  assign at_mid    = (timer == mid);
  assign resolve   = (timer == mid - CW'(1));
  assign maj       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign div_ok    = (clock_divider_i >= CW'(4));
  assign last_idx  = {1'b0, cfg_bits} + 3'd4;

  always_comb begin
    case (cfg_par)
      PARITY_EVEN: exp_par = ^shreg;
      PARITY_ODD:  exp_par = ~^shreg;
      PARITY_MARK: exp_par = 1'b1;
      default:     exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE:
        if (armed && !rx_s && div_ok) begin
          start_go  = 1'b1;
          state_nxt = ST_START;
        end
      ST_START:
        if (resolve) state_nxt = maj ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (resolve && bit_idx == last_idx)
          state_nxt = parity_enabled(cfg_par) ? ST_PARITY : ST_STOP;
      ST_PARITY:
        if (resolve) state_nxt = ST_STOP;
      ST_STOP:
        if (resolve && stop_idx == cfg_stop) state_nxt = ST_PUSH;
      ST_PUSH: begin
        push      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      armed     <= 1'b0;
      timer     <= '0;
      cfg_bits  <= '0;
      cfg_par   <= '0;
      cfg_stop  <= 1'b0;
      s_a       <= 1'b0;
      s_b       <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      all_zero  <= 1'b0;
    end else begin
      sync1 <= serial_i;
      rx_s  <= sync1;
      if (start_go)
        timer <= clock_divider_i - CW'(1);
      else if (state != ST_IDLE)
        timer <= (timer == '0) ? clock_divider_i - CW'(1) : timer - CW'(1);
      if (at_mid_p1) s_a <= rx_s;
      if (at_mid)    s_b <= rx_s;
      case (state)
        ST_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_go) begin
            cfg_bits  <= data_bits_i;
            cfg_par   <= parity_mode_i;
            cfg_stop  <= stop_bits_i;
            shreg     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            all_zero  <= 1'b1;
          end
        end
        ST_DATA:
          if (resolve) begin
            shreg[bit_idx] <= maj;
            bit_idx        <= bit_idx + 3'd1;
            all_zero       <= all_zero & ~maj;
          end
        ST_PARITY:
          if (resolve) begin
            par_err  <= (maj != exp_par);
            all_zero <= all_zero & ~maj;
          end
        ST_STOP:
          if (resolve) begin
            if (!maj) frame_err <= 1'b1;
            all_zero <= all_zero & ~maj;
            stop_idx <= 1'b1;
          end
        // Re-arm only once the line is seen high again, so a held break
        // produces exactly one entry.
        ST_PUSH: armed <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    entry                    = '0;
    entry[DATA_MSB:DATA_LSB] = shreg;
    entry[FRAME_BIT]         = frame_err;
    entry[PARITY_BIT]        = par_err;
    entry[BREAK_BIT]         = all_zero;
  end

  assign pop = !fifo_empty && ready_i;

  uart_sync_fifo #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clock_i),
    .rst       (reset_i),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i)                          overrun_o <= 1'b0;
    else if (push && fifo_full && !pop)   overrun_o <= 1'b1;
    else if (clear_overrun_i)             overrun_o <= 1'b0;
  end

  assign data_o       = head[DATA_MSB:DATA_LSB];
  assign frame_err_o  = head[FRAME_BIT];
  assign parity_err_o = head[PARITY_BIT];
  assign break_o      = head[BREAK_BIT];
  assign valid_o      = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of frame formats plus hand-written
// sequences for break, glitch, overrun and mid-frame reset.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] clock_divider_i;
  logic        serial_i;
  logic [1:0]  data_bits_i;
  logic [2:0]  parity_mode_i;
  logic        stop_bits_i;
  logic [7:0]  data_o;
  logic        frame_err_o, parity_err_o, break_o, valid_o;
  logic        ready_i;
  logic [4:0]  level_o;
  logic        overrun_o;
  logic        clear_overrun_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_q = 1'b0;

  localparam int DIV = 16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_o && !valid_q) rise_cyc = cyc;
    valid_q = valid_o;
  end

  uart_rx_fifo dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .clock_divider_i (clock_divider_i),
    .serial_i        (serial_i),
    .data_bits_i     (data_bits_i),
    .parity_mode_i   (parity_mode_i),
    .stop_bits_i     (stop_bits_i),
    .data_o          (data_o),
    .frame_err_o     (frame_err_o),
    .parity_err_o    (parity_err_o),
    .break_o         (break_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .level_o         (level_o),
    .overrun_o       (overrun_o),
    .clear_overrun_i (clear_overrun_i)
  );

  typedef struct {
    logic [1:0] dbits;
    logic [2:0] pmode;
    logic       stops;
    logic [7:0] din;
    logic       bad_par;
    logic       bad_stop;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_brk;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [1:0] db, input logic [2:0] pm, input logic st,
                              input logic [7:0] d, input logic bp, input logic bs,
                              input logic [7:0] ed, input logic efe, input logic epe, input logic ebk);
    vec_t v;
    v.dbits = db; v.pmode = pm; v.stops = st; v.din = d; v.bad_par = bp; v.bad_stop = bs;
    v.exp_d = ed; v.exp_fe = efe; v.exp_pe = epe; v.exp_brk = ebk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (DIV) @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [2:0] pm,
                            input logic st, input logic bad_par, input logic bad_stop);
    logic [7:0] mask;
    logic [7:0] dm;
    logic       p;
    mask = 8'hFF >> (8 - nb);
    dm   = d & mask;
    case (pm)
      3'd1:    p = ^dm;
      3'd2:    p = ~^dm;
      3'd3:    p = 1'b1;
      default: p = 1'b0;
    endcase
    if (bad_par) p = ~p;
    @(negedge clk);
    serial_i  = 1'b0;
    start_cyc = cyc;
    bit_wait();
    for (int i = 0; i < nb; i++) begin
      serial_i = d[i];
      bit_wait();
    end
    if (pm >= 3'd1 && pm <= 3'd4) begin
      serial_i = p;
      bit_wait();
    end
    serial_i = ~bad_stop;
    bit_wait();
    if (st) begin
      serial_i = 1'b1;
      bit_wait();
    end
    serial_i = 1'b1;
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    int nb, total;
    reset_i = 1'b1; clock_divider_i = 16'(DIV); serial_i = 1'b1;
    data_bits_i = 2'd3; parity_mode_i = 3'd0; stop_bits_i = 1'b0;
    ready_i = 1'b0; clear_overrun_i = 1'b0;
    cycles(3);
    chk("reset_valid", valid_o, 0);
    chk("reset_level", level_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_overrun", overrun_o, 0);
    chk("reset_flags", {break_o, parity_err_o, frame_err_o}, 0);
    reset_i = 1'b0;
    cycles(40);

    vecs[0] = mk(2'd3, 3'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(2'd2, 3'd1, 1'b1, 8'h35, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0);
    vecs[2] = mk(2'd2, 3'd1, 1'b1, 8'h35, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(2'd0, 3'd2, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(2'd1, 3'd3, 1'b0, 8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(2'd3, 3'd4, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    vecs[6] = mk(2'd1, 3'd4, 1'b1, 8'h15, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0);

    foreach (vecs[k]) begin
      data_bits_i = vecs[k].dbits; parity_mode_i = vecs[k].pmode; stop_bits_i = vecs[k].stops;
      nb    = int'(vecs[k].dbits) + 5;
      total = 1 + nb + ((vecs[k].pmode != 3'd0) ? 1 : 0) + 1 + int'(vecs[k].stops);
      rise_cyc = -1;
      send_frame(vecs[k].din, nb, vecs[k].pmode, vecs[k].stops, vecs[k].bad_par, vecs[k].bad_stop);
      cycles(8);
      chk($sformatf("v%0d_latency", k), rise_cyc - start_cyc, DIV * total - 3);
      chk($sformatf("v%0d_data", k), data_o, vecs[k].exp_d);
      chk($sformatf("v%0d_frame_err", k), frame_err_o, vecs[k].exp_fe);
      chk($sformatf("v%0d_parity_err", k), parity_err_o, vecs[k].exp_pe);
      chk($sformatf("v%0d_break", k), break_o, vecs[k].exp_brk);
      chk($sformatf("v%0d_level", k), level_o, 1);
      pop_one();
      chk($sformatf("v%0d_level_after_pop", k), level_o, 0);
      cycles(DIV);
    end

    // Break: line held low for 20 bit times in 8N1.
    data_bits_i = 2'd3; parity_mode_i = 3'd0; stop_bits_i = 1'b0;
    @(negedge clk);
    serial_i = 1'b0;
    cycles(20 * DIV);
    serial_i = 1'b1;
    cycles(3 * DIV);
    chk("break_level", level_o, 1);
    chk("break_data", data_o, 8'h00);
    chk("break_flag", break_o, 1);
    chk("break_frame_err", frame_err_o, 1);
    chk("break_parity_err", parity_err_o, 0);
    pop_one();
    chk("break_level_after_pop", level_o, 0);

    // Short low glitch on the idle line.
    @(negedge clk);
    serial_i = 1'b0;
    cycles(3);
    serial_i = 1'b1;
    cycles(3 * DIV);
    chk("glitch_level", level_o, 0);
    chk("glitch_valid", valid_o, 0);

    // Overrun: 17 frames with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 3'd0, 1'b0, 1'b0, 1'b0);
      cycles(DIV);
    end
    chk("ovr_level", level_o, 16);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_head", data_o, 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), data_o, 8'(i));
      pop_one();
    end
    chk("drain_level", level_o, 0);
    chk("ovr_sticky", overrun_o, 1);
    clear_overrun_i = 1'b1;
    @(negedge clk);
    clear_overrun_i = 1'b0;
    chk("ovr_cleared", overrun_o, 0);

    // Reset in the middle of a frame, with one entry already queued.
    send_frame(8'h11, 8, 3'd0, 1'b0, 1'b0, 1'b0);
    cycles(DIV);
    chk("pre_reset_level", level_o, 1);
    @(negedge clk);
    serial_i = 1'b0;
    bit_wait();
    serial_i = 1'b1;
    cycles(2 * DIV);
    reset_i = 1'b1;
    cycles(2);
    reset_i = 1'b0;
    serial_i = 1'b1;
    cycles(1);
    chk("mid_reset_level", level_o, 0);
    chk("mid_reset_valid", valid_o, 0);
    chk("mid_reset_data", data_o, 0);
    chk("mid_reset_overrun", overrun_o, 0);
    cycles(8 * DIV);
    chk("mid_reset_no_entry", level_o, 0);
    send_frame(8'h5A, 8, 3'd0, 1'b0, 1'b0, 1'b0);
    cycles(8);
    chk("post_reset_level", level_o, 1);
    chk("post_reset_data", data_o, 8'h5A);
    chk("post_reset_flags", {break_o, parity_err_o, frame_err_o}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
